// File: rtl/avs_slave_pkg.sv
// Register map, bit positions and channel state type shared by avalon_slave_regfile.
// Build option AVS_SLAVE_IRQ_EN adds the irq output and a stored CONTROL.ie bit.
package avs_slave_pkg;

    localparam logic [1:0] REG_START   = 2'd0;
    localparam logic [1:0] REG_END     = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_CONTROL = 2'd3;

    localparam int ST_BUSY   = 0;
    localparam int ST_DONE   = 1;
    localparam int ST_ERR    = 2;

    localparam int CTL_GO    = 0;
    localparam int CTL_ABORT = 1;
    localparam int CTL_IE    = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

endpackage

// File: rtl/avs_channel_fsm.sv
// One pixel-range channel: START/END registers, sticky done/err bits, ie and run FSM.
// ie is only stored when AVS_SLAVE_IRQ_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for a go write; START/END writable
//   RUN   | core processing the range; busy=1, waits for done or abort
module avs_channel_fsm
    import avs_slave_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                wr_start,
    input  logic                wr_end,
    input  logic                wr_status,
    input  logic                wr_control,
    input  logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic                done,
    output logic [DATA_W-1:0]   start_q,
    output logic [DATA_W-1:0]   end_q,
    output logic                st_done,
    output logic                st_err,
    output logic                ie,
    output logic                start_pulse,
    output logic                busy
);

    chan_state_t state;
    logic        go;
    logic        abort;
    logic        ctl_lane0;

    assign ctl_lane0 = wr_control && byteenable[0];
    assign go        = ctl_lane0 && writedata[CTL_GO];
    assign abort     = ctl_lane0 && writedata[CTL_ABORT];
    assign busy      = (state == RUN);

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] cur);
        logic [DATA_W-1:0] res;
        res = cur;
        for (int b = 0; b < DATA_W/8; b++) begin
            if (byteenable[b]) res[b*8 +: 8] = writedata[b*8 +: 8];
        end
        return res;
    endfunction

    // W1C clears are applied first so a same-cycle set overrides them.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            start_q     <= '0;
            end_q       <= '0;
            st_done     <= 1'b0;
            st_err      <= 1'b0;
            start_pulse <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            if (wr_status && byteenable[0]) begin
                if (writedata[ST_DONE]) st_done <= 1'b0;
                if (writedata[ST_ERR])  st_err  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (wr_start) start_q <= merge_bytes(start_q);
                    if (wr_end)   end_q   <= merge_bytes(end_q);
                    if (go) begin
                        if (start_q <= end_q) begin
                            state       <= RUN;
                            start_pulse <= 1'b1;
                        end else begin
                            st_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (wr_start || wr_end) st_err <= 1'b1;
                    if (done) begin
                        state   <= IDLE;
                        st_done <= 1'b1;
                    end else if (abort) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AVS_SLAVE_IRQ_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)         ie <= 1'b0;
        else if (ctl_lane0) ie <= writedata[CTL_IE];
    end
`else
    assign ie = 1'b0;
`endif

endmodule

// File: rtl/avalon_slave_regfile.sv
// Avalon-MM slave register file with NUM_CH independent Sobel pixel-range channels.
// Build option AVS_SLAVE_IRQ_EN adds the registered irq output.
module avalon_slave_regfile
    import avs_slave_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          NUM_CH   = 2,
    parameter int          ADDR_W   = 4,
    parameter logic [31:0] ID_VALUE = 32'h50B3_0002
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     read,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        address,
    input  logic [DATA_W-1:0]        writedata,
    input  logic [DATA_W/8-1:0]      byteenable,
    output logic [DATA_W-1:0]        readdata,
    output logic                     readdatavalid,
    input  logic [NUM_CH-1:0]        done,
    output logic [NUM_CH*DATA_W-1:0] startpixel,
    output logic [NUM_CH*DATA_W-1:0] endpixel,
    output logic [NUM_CH-1:0]        start_pulse,
    output logic [NUM_CH-1:0]        busy
`ifdef AVS_SLAVE_IRQ_EN
    ,
    output logic                     irq
`endif
);

    localparam int CH_W = ADDR_W - 2;

    logic [CH_W-1:0]   ch;
    logic [1:0]        off;
    logic              in_range;
    logic              wr_fire;
    logic              rd_fire;
    logic [DATA_W-1:0] rd_mux;
    logic [NUM_CH-1:0] st_done;
    logic [NUM_CH-1:0] st_err;
    logic [NUM_CH-1:0] ie_q;

    assign ch       = address[ADDR_W-1:2];
    assign off      = address[1:0];
    assign in_range = int'(ch) < NUM_CH;
    assign wr_fire  = write && in_range;
    // A write wins over a simultaneous read; the read is dropped entirely.
    assign rd_fire  = read && !write;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = wr_fire && (int'(ch) == i);

        avs_channel_fsm #(.DATA_W(DATA_W)) u_ch (
            .clk         (clk),
            .n_rst       (n_rst),
            .wr_start    (sel && (off == REG_START)),
            .wr_end      (sel && (off == REG_END)),
            .wr_status   (sel && (off == REG_STATUS)),
            .wr_control  (sel && (off == REG_CONTROL)),
            .writedata   (writedata),
            .byteenable  (byteenable),
            .done        (done[i]),
            .start_q     (startpixel[i*DATA_W +: DATA_W]),
            .end_q       (endpixel[i*DATA_W +: DATA_W]),
            .st_done     (st_done[i]),
            .st_err      (st_err[i]),
            .ie          (ie_q[i]),
            .start_pulse (start_pulse[i]),
            .busy        (busy[i])
        );
    end

    always_comb begin
        rd_mux = '0;
        if (in_range) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (int'(ch) == i) begin
                    case (off)
                        REG_START:  rd_mux = startpixel[i*DATA_W +: DATA_W];
                        REG_END:    rd_mux = endpixel[i*DATA_W +: DATA_W];
                        REG_STATUS: begin
                            rd_mux[ST_BUSY] = busy[i];
                            rd_mux[ST_DONE] = st_done[i];
                            rd_mux[ST_ERR]  = st_err[i];
                        end
                        default:    rd_mux[CTL_IE] = ie_q[i];
                    endcase
                end
            end
        end else if ((&ch) && (off == REG_START)) begin
            rd_mux = DATA_W'(ID_VALUE);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= rd_fire;
            readdata      <= rd_fire ? rd_mux : '0;
        end
    end

`ifdef AVS_SLAVE_IRQ_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) irq <= 1'b0;
        else        irq <= |(st_done & ie_q);
    end
`endif

endmodule

// File: tb/tb_avalon_slave_regfile.sv
// Directed bench for avalon_slave_regfile with a per-channel behavioural model.
module tb_avalon_slave_regfile;

    localparam int          NUM_CH = 2;
    localparam logic [31:0] ID_VAL = 32'h50B3_0002;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [3:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [1:0]  done = '0;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic [63:0] startpixel;
    logic [63:0] endpixel;
    logic [1:0]  start_pulse;
    logic [1:0]  busy;
`ifdef AVS_SLAVE_IRQ_EN
    logic        irq;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    avalon_slave_regfile dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .done          (done),
        .startpixel    (startpixel),
        .endpixel      (endpixel),
        .start_pulse   (start_pulse),
        .busy          (busy)
`ifdef AVS_SLAVE_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_start[NUM_CH];
    logic [31:0] m_end[NUM_CH];
    bit          m_run[NUM_CH];
    bit          m_done[NUM_CH];
    bit          m_err[NUM_CH];
    bit          m_ie[NUM_CH];
    bit          m_pulse[NUM_CH];
    bit          was_run[NUM_CH];
    logic [31:0] m_rdata;
    bit          m_rdv;
    bit          m_irq;
    int          mc;
    int          mo;

    function automatic logic [31:0] model_read(input logic [3:0] a);
        int c;
        int o;
        c = int'(a[3:2]);
        o = int'(a[1:0]);
        if (c < NUM_CH) begin
            case (o)
                0:       return m_start[c];
                1:       return m_end[c];
                2:       return {29'd0, m_err[c], m_done[c], m_run[c]};
                default: return {29'd0, m_ie[c], 2'b00};
            endcase
        end
        if (c == 3 && o == 0) return ID_VAL;
        return 32'd0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                m_start[k] = '0; m_end[k] = '0; m_run[k] = 0; m_done[k] = 0;
                m_err[k] = 0; m_ie[k] = 0; m_pulse[k] = 0;
            end
            m_rdata = '0; m_rdv = 0; m_irq = 0;
        end else begin
            m_irq = (m_done[0] && m_ie[0]) || (m_done[1] && m_ie[1]);
            m_rdv = read && !write;
            m_rdata = m_rdv ? model_read(address) : 32'd0;
            for (int k = 0; k < NUM_CH; k++) begin
                was_run[k] = m_run[k];
                m_pulse[k] = 0;
            end
            mc = int'(address[3:2]);
            mo = int'(address[1:0]);
            if (write && mc < NUM_CH) begin
                case (mo)
                    0, 1: begin
                        if (was_run[mc])  m_err[mc] = 1;
                        else if (mo == 0) m_start[mc] = merge(m_start[mc], writedata, byteenable);
                        else              m_end[mc] = merge(m_end[mc], writedata, byteenable);
                    end
                    2: if (byteenable[0]) begin
                        if (writedata[1]) m_done[mc] = 0;
                        if (writedata[2]) m_err[mc] = 0;
                    end
                    default: if (byteenable[0]) begin
`ifdef AVS_SLAVE_IRQ_EN
                        m_ie[mc] = writedata[2];
`endif
                        if (writedata[0] && !was_run[mc]) begin
                            if (m_start[mc] <= m_end[mc]) begin
                                m_run[mc] = 1;
                                m_pulse[mc] = 1;
                            end else begin
                                m_err[mc] = 1;
                            end
                        end
                        if (writedata[1] && was_run[mc] && !done[mc]) m_run[mc] = 0;
                    end
                endcase
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (was_run[k] && done[k]) begin
                    m_run[k] = 0;
                    m_done[k] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("readdatavalid", readdatavalid, m_rdv);
        chk("readdata", readdata, m_rdata);
        chk("busy", busy, {m_run[1], m_run[0]});
        chk("start_pulse", start_pulse, {m_pulse[1], m_pulse[0]});
        chk("startpixel", startpixel, {m_start[1], m_start[0]});
        chk("endpixel", endpixel, {m_end[1], m_end[0]});
`ifdef AVS_SLAVE_IRQ_EN
        chk("irq", irq, m_irq);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic bus(input logic r, input logic w, input logic [3:0] a,
                       input logic [31:0] wd, input logic [3:0] be, input logic [1:0] dn);
        read = r; write = w; address = a; writedata = wd; byteenable = be; done = dn;
        @(posedge clk);
        #1;
        read = 0; write = 0; address = '0; writedata = '0; byteenable = '0; done = '0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] wd);
        bus(1'b0, 1'b1, a, wd, 4'hF, 2'b00);
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp, input string nm);
        bus(1'b1, 1'b0, a, 32'd0, 4'h0, 2'b00);
        chk({nm, "_rdv"}, readdatavalid, 1'b1);
        chk(nm, readdata, exp);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 2'b00);
        chk("rst_rdv", readdatavalid, 1'b0);
        chk("rst_rdata", readdata, 32'd0);
        n_rst = 1;
        rd_chk(4'd2, 32'd0, "rst_status");

        wr(4'd0, 32'd4444);
        wr(4'd1, 32'd6666);
        wr(4'd3, 32'd1);
        chk("go_pulse", start_pulse, 2'b01);
        chk("go_busy", busy, 2'b01);
        rd_chk(4'd2, 32'd1, "run_status");
        chk("pulse_once", start_pulse, 2'b00);
        chk("start_lit", startpixel[31:0], 32'd4444);
        chk("end_lit", endpixel[31:0], 32'd6666);

        wr(4'd0, 32'd1234);
        rd_chk(4'd0, 32'd4444, "start_locked");
        rd_chk(4'd2, 32'd5, "err_in_run");
        wr(4'd2, 32'd4);
        rd_chk(4'd2, 32'd1, "err_cleared");

        wr(4'd3, 32'd4);
        bus(1'b0, 1'b0, 4'd0, 32'd0, 4'h0, 2'b01);
        chk("done_busy", busy, 2'b00);
        rd_chk(4'd2, 32'd2, "done_status");
`ifdef AVS_SLAVE_IRQ_EN
        chk("irq_set", irq, 1'b1);
        rd_chk(4'd3, 32'd4, "ie_read");
`else
        rd_chk(4'd3, 32'd0, "ie_read");
`endif
        wr(4'd2, 32'd2);
        rd_chk(4'd2, 32'd0, "done_cleared");
`ifdef AVS_SLAVE_IRQ_EN
        chk("irq_clr", irq, 1'b0);
`endif

        wr(4'd4, 32'd6666);
        wr(4'd5, 32'd4444);
        wr(4'd7, 32'd1);
        chk("ch1_err_busy", busy, 2'b00);
        rd_chk(4'd6, 32'd4, "ch1_err");

        wr(4'd4, 32'd0);
        bus(1'b0, 1'b1, 4'd4, 32'hFFFF_FFFF, 4'b0011, 2'b00);
        rd_chk(4'd4, 32'h0000_FFFF, "be_low");
        bus(1'b0, 1'b1, 4'd5, 32'hAABB_CCDD, 4'b1100, 2'b00);
        rd_chk(4'd5, 32'hAABB_115C, "be_high");

        bus(1'b0, 1'b0, 4'd0, 32'd0, 4'h0, 2'b10);
        rd_chk(4'd6, 32'd4, "idle_done");

        wr(4'd3, 32'd1);
        bus(1'b0, 1'b1, 4'd3, 32'd2, 4'hF, 2'b01);
        rd_chk(4'd2, 32'd2, "done_wins");
        wr(4'd2, 32'd2);

        wr(4'd3, 32'd1);
        wr(4'd3, 32'd2);
        chk("abort_busy", busy, 2'b00);
        rd_chk(4'd2, 32'd0, "abort_status");

        bus(1'b1, 1'b1, 4'd0, 32'd100, 4'hF, 2'b00);
        chk("rw_rdv", readdatavalid, 1'b0);
        rd_chk(4'd0, 32'd100, "rw_write");

        wr(4'd8, 32'h1234);
        rd_chk(4'd8, 32'd0, "ch2_rd");
        rd_chk(4'd12, ID_VAL, "id_rd");
        rd_chk(4'd13, 32'd0, "ch3_off1");

        wr(4'd3, 32'd1);
        chk("pre_rst_busy", busy, 2'b01);
        #2 n_rst = 0;
        #1 chk("rst_async_busy", busy, 2'b00);
        @(posedge clk);
        #1 n_rst = 1;
        rd_chk(4'd2, 32'd0, "post_rst_status");
        chk("post_rst_start", startpixel, 64'd0);

        repeat (2) bus(1'b0, 1'b0, 4'd0, 32'd0, 4'h0, 2'b00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/avalon_slave_regfile.md
# avalon_slave_regfile

Parametrised Avalon-MM slave register file for the Sobel edge-detection accelerator. It replaces the single-channel slave FSM with NUM_CH independent pixel-range channels. Each channel has its own start/end-pixel registers, its own control/status pair, and its own run FSM handshaking with the processing core. It sits between the Avalon-MM fabric and the per-channel Sobel datapaths.

## Interface
- DATA_W, 32, register/bus data width; multiple of 8
- NUM_CH, 2, number of channels; 1..2^(ADDR_W-2)
- ADDR_W, 4, word-address width
- ID_VALUE, 32'h50B3_0002, constant for unused register offset reads (see map)

- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- read  in  1  Avalon read strobe
- write  in  1  Avalon write strobe
- address  in  ADDR_W  word address: [ADDR_W-1:2] channel, [1:0] register
- writedata  in  DATA_W  write data
- byteenable  in  DATA_W/8  write byte-lane enables
- readdata  out  DATA_W  read data, valid with readdatavalid
- readdatavalid  out  1  one-cycle read-return strobe
- done  in  NUM_CH  per-channel one-cycle completion pulse from core
- startpixel  out  NUM_CH*DATA_W  packed START registers, channel 0 in LSBs
- endpixel  out  NUM_CH*DATA_W  packed END registers
- start_pulse  out  NUM_CH  one-cycle launch strobe per channel
- busy  out  NUM_CH  channel in RUN
- irq  out  1  present only with AVS_SLAVE_IRQ_EN

## Operation
- Register offsets per channel: 0 START (RW), 1 END (RW), 2 STATUS (RO except W1C bits), 3 CONTROL (RW).
- STATUS bits: [0] busy, [1] done (sticky, W1C), [2] err (sticky, W1C). All other bits read 0.
- CONTROL bits: [0] go (self-clearing, always reads 0), [1] abort (self-clearing, always reads 0), [2] ie (stored; reads 0 without IRQ macro).
- Channel FSM states: IDLE and RUN.
  - IDLE -> RUN on a go write when START <= END (unsigned). start_pulse fires for exactly the first RUN cycle.
  - A go write with START > END stays in IDLE and sets err.
  - RUN -> IDLE on done: sets the done bit.
  - RUN -> IDLE on abort: done is not set.
  - done and abort in the same cycle: done wins.
- Writes to START or END while in RUN are dropped and set err. A go write while in RUN is ignored.
- done pulses received in IDLE are ignored.
- W1C clear and a new set of the same bit in the same cycle: set wins.
- Byte lanes with byteenable=0 are unchanged.
- Write and read in the same cycle: the write executes. The read is discarded and readdatavalid stays 0.
- Out-of-range channel index:
  - Writes are ignored.
  - Reads return 0, except channel field all-ones with offset 0, which returns ID_VALUE.

## Timing
- Reset: all registers 0, every FSM in IDLE; readdata=0, readdatavalid=0, start_pulse=0, busy=0, irq=0.
- Write sampled at edge k: register, busy and start_pulse reflect it from k+1.
- Read sampled at edge k: readdata is valid with readdatavalid=1 during cycle k+1. readdata=0 otherwise. No waitrequest; back-to-back reads are accepted every cycle.
- done sampled at edge k: busy=0 and status.done=1 from k+1.
- Reset asserted mid-RUN: the channel drops to IDLE immediately (asynchronously). No done is recorded.

## Configuration
- AVS_SLAVE_IRQ_EN defined:
  - irq port exists.
  - irq = OR over channels of (status.done & control.ie), registered, so it rises one cycle after done is set.
- AVS_SLAVE_IRQ_EN undefined:
  - No irq port.
  - ie bit is not stored and reads 0.

## Structure
- Package avs_slave_pkg holds:
  - register offset constants (REG_START, REG_END, REG_STATUS, REG_CONTROL)
  - STATUS/CONTROL bit-position constants
  - the chan_state_t enum {IDLE, RUN}
- Sub-module avs_channel_fsm is instantiated NUM_CH times via generate. It holds START/END/ie, the FSM, and the sticky bits.
- The top holds address decode, the read mux/pipeline register and the irq OR.

## Test plan
- Reset: hold n_rst=0 for 2 cycles -> all outputs 0; read ch0 STATUS returns 0.
- Program ch0: write START=4444, END=6666, then CONTROL=1 -> startpixel[31:0]=4444, endpixel[31:0]=6666, one start_pulse[0] cycle, busy[0]=1; read STATUS=1 one cycle later with readdatavalid.
- Complete ch0: pulse done[0] -> STATUS reads 2; write STATUS=2 -> STATUS reads 0. With the macro and ie=1, irq=1 until the clear.
- Error: ch1 START=6666, END=4444, go -> busy[1]=0, STATUS[2]=1. A write to START during ch0 RUN leaves the value unchanged and sets err.
- Byte enables: write 32'hFFFF_FFFF with byteenable=4'b0011 to a START holding 0 -> reads 32'h0000_FFFF.
- Corner cases:
  - done and abort in the same cycle -> STATUS.done=1.
  - Reset mid-RUN -> busy=0, STATUS=0.
  - Read of channel 3, offset 0 -> ID_VALUE.
